bus_arb_mux: RTL and testbench

Parametrised successor to the datapath bus multiplexer. It selects one of NUM_SRC register/port sources onto a registered system bus, with selectable fixed-priority or round-robin arbitration. It also provides multi-driver conflict detection with a saturating counter and a hold (freeze) control. It sits between the register file, special registers and the bus consumers (ALU Y/Z inputs, MAR, MDR, register inputs).

---
 rtl/bus_pkg.sv | 45 ++++
 rtl/bus_rr_arbiter.sv | 45 ++++
 rtl/bus_arb_mux.sv | 113 +++++++++++
 tb/tb_bus_arb_mux.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the system-bus multiplexer.
//   - default WIDTH / NUM_SRC / CNT_W
//   - arbitration mode encodings (ARB_FIXED, ARB_RR)
//   - named source indices matching the legacy strobe order
package bus_pkg;

  localparam int BUS_WIDTH_DEF   = 32;
  localparam int BUS_NUM_SRC_DEF = 24;
  localparam int BUS_CNT_W_DEF   = 16;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Source indices; lower index = higher fixed priority.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Pointer width that is never zero, even for a single source.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: combinational arbiter for the system bus.
//   req_i   : per-source requests (output enables)
//   ptr_i   : last granted index (round-robin only)
//   gnt_o   : one-hot grant, all-zero when no request
//   idx_o   : binary index of the granted source
//   any_o   : at least one request
//   multi_o : two or more requests (conflict)
// Fixed mode is the round-robin search with the start forced to index 0.
module bus_rr_arbiter import bus_pkg::*; #(
  parameter int NUM_SRC = BUS_NUM_SRC_DEF,
  parameter int RR_MODE = ARB_FIXED,
  parameter int PTR_W   = ptr_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o,
  output logic               multi_o
);

  always_comb begin
    int start;
    int idx;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    start = (RR_MODE == ARB_RR) ? ((int'(ptr_i) + 1) % NUM_SRC) : 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = start + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        idx_o      = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

  assign any_o   = |req_i;
  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign multi_o = |(req_i & (req_i - NUM_SRC'(1)));

endmodule

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: arbitrated, registered system-bus multiplexer.
//   clock          : rising-edge clock
//   clear          : synchronous active-high reset (beats hold)
//   src_data       : NUM_SRC concatenated words, source i at [i*WIDTH +: WIDTH]
//   src_out        : per-source output enables
//   hold           : freeze every register for the cycle
//   bus_out        : registered bus word (0 when idle)
//   bus_valid      : bus_out came from a granted source
//   grant          : registered one-hot grant behind bus_out
//   conflict       : registered flag, 2+ enables in the sampled cycle
//   conflict_count : saturating count of conflict cycles
//   bus_parity     : XOR of bus_out (only with BUS_PARITY_EN defined)
// Optional feature macro: BUS_PARITY_EN.
module bus_arb_mux import bus_pkg::*; #(
  parameter int WIDTH   = BUS_WIDTH_DEF,
  parameter int NUM_SRC = BUS_NUM_SRC_DEF,
  parameter int RR_MODE = ARB_FIXED,
  parameter int CNT_W   = BUS_CNT_W_DEF
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_out,
  input  logic                     hold,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     conflict,
  output logic [CNT_W-1:0]         conflict_count
`ifdef BUS_PARITY_EN
  , output logic                   bus_parity
`endif
);

  localparam int PTR_W = ptr_width(NUM_SRC);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any, arb_multi;

  logic [WIDTH-1:0]   bus_d, bus_q;
  logic               vld_d, vld_q;
  logic [NUM_SRC-1:0] gnt_d, gnt_q;
  logic               conf_d, conf_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [PTR_W-1:0]   ptr_d, ptr_q;

  bus_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .RR_MODE (RR_MODE),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (src_out),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any),
    .multi_o (arb_multi)
  );

  // AND-OR mux: masked-off sources contribute zero, so their data
  // (even X) never reaches the bus.
  always_comb begin
    bus_d = '0;
    for (int i = 0; i < NUM_SRC; i++)
      bus_d = bus_d | (src_data[i*WIDTH +: WIDTH] & {WIDTH{arb_gnt[i]}});
  end

  always_comb begin
    vld_d  = arb_any;
    gnt_d  = arb_gnt;
    conf_d = arb_multi;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    if (arb_multi && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    if (arb_any) ptr_d = arb_idx;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      bus_q  <= '0;
      vld_q  <= 1'b0;
      gnt_q  <= '0;
      conf_q <= 1'b0;
      cnt_q  <= '0;
      ptr_q  <= PTR_RST;
    end else if (!hold) begin
      bus_q  <= bus_d;
      vld_q  <= vld_d;
      gnt_q  <= gnt_d;
      conf_q <= conf_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus_out        = bus_q;
  assign bus_valid      = vld_q;
  assign grant          = gnt_q;
  assign conflict       = conf_q;
  assign conflict_count = cnt_q;

`ifdef BUS_PARITY_EN
  logic par_q;
  always_ff @(posedge clock) begin
    if (clear)      par_q <= 1'b0;
    else if (!hold) par_q <= ^bus_d;
  end
  assign bus_parity = par_q;
`endif

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb_bus_arb_mux: drives a fixed-priority instance (CNT_W=4) and a
// round-robin instance (CNT_W=16) from the same inputs and compares both
// against a cycle-level behavioural model. Build with +define+BUS_PARITY_EN
// to cover the parity output.
module tb_bus_arb_mux;
  localparam int W = 32;
  localparam int N = 24;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic hold  = 1'b0;
  logic [N-1:0]   src_out  = '0;
  logic [N*W-1:0] src_data = '0;

  logic [W-1:0] b0, b1;
  logic         v0, v1, c0, c1;
  logic [N-1:0] g0, g1;
  logic [3:0]   n0;
  logic [15:0]  n1;
`ifdef BUS_PARITY_EN
  logic p0, p1;
`endif

  always #5 clock = ~clock;

  bus_arb_mux #(.WIDTH(W), .NUM_SRC(N), .RR_MODE(0), .CNT_W(4)) dut_fix (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
    .hold(hold), .bus_out(b0), .bus_valid(v0), .grant(g0), .conflict(c0),
    .conflict_count(n0)
`ifdef BUS_PARITY_EN
    , .bus_parity(p0)
`endif
  );

  bus_arb_mux #(.WIDTH(W), .NUM_SRC(N), .RR_MODE(1), .CNT_W(16)) dut_rr (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
    .hold(hold), .bus_out(b1), .bus_valid(v1), .grant(g1), .conflict(c1),
    .conflict_count(n1)
`ifdef BUS_PARITY_EN
    , .bus_parity(p1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = fixed instance, 1 = round-robin instance.
  logic [W-1:0] e_bus [2];
  logic         e_vld [2];
  logic [N-1:0] e_gnt [2];
  logic         e_conf[2];
  int           e_cnt [2];
  int           e_ptr [2];
  int           cmax  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [W-1:0] val);
    src_data[i*W +: W] = val;
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int w;
      int pop;
      if (clear) begin
        e_bus[m] = '0; e_vld[m] = 1'b0; e_gnt[m] = '0; e_conf[m] = 1'b0;
        e_cnt[m] = 0;  e_ptr[m] = N - 1;
      end else if (!hold) begin
        w   = -1;
        pop = $countones(src_out);
        if (m == 0) begin
          for (int i = 0; i < N; i++) if (w < 0 && src_out[i]) w = i;
        end else begin
          for (int k = 1; k <= N; k++) begin
            int i;
            i = (e_ptr[m] + k) % N;
            if (w < 0 && src_out[i]) w = i;
          end
        end
        if (w < 0) begin
          e_bus[m] = '0; e_vld[m] = 1'b0; e_gnt[m] = '0; e_conf[m] = 1'b0;
        end else begin
          e_bus[m]  = src_data[w*W +: W];
          e_vld[m]  = 1'b1;
          e_gnt[m]  = '0;
          e_gnt[m][w] = 1'b1;
          e_conf[m] = (pop > 1);
          if (e_conf[m] && e_cnt[m] < cmax[m]) e_cnt[m]++;
          e_ptr[m]  = w;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("fix_bus",   b0, e_bus[0]);
    chk("fix_vld",   v0, e_vld[0]);
    chk("fix_gnt",   g0, e_gnt[0]);
    chk("fix_conf",  c0, e_conf[0]);
    chk("fix_cnt",   n0, e_cnt[0]);
    chk("fix_onehot", $onehot0(g0), 1);
    chk("rr_bus",    b1, e_bus[1]);
    chk("rr_vld",    v1, e_vld[1]);
    chk("rr_gnt",    g1, e_gnt[1]);
    chk("rr_conf",   c1, e_conf[1]);
    chk("rr_cnt",    n1, e_cnt[1]);
    chk("rr_onehot", $onehot0(g1), 1);
`ifdef BUS_PARITY_EN
    chk("fix_par",   p0, ^e_bus[0]);
    chk("rr_par",    p1, ^e_bus[1]);
`endif
  endtask

  // Inputs change only at posedge+1, so the model sees the sampled values.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) set_word(i, $urandom);
  endtask

  initial begin
    int exp_rr[4];
    logic [N-1:0] one;
    logic [N-1:0] rr_set;
    cmax[0] = 15;
    cmax[1] = 65535;
    for (int m = 0; m < 2; m++) begin
      e_bus[m] = '0; e_vld[m] = 1'b0; e_gnt[m] = '0; e_conf[m] = 1'b0;
      e_cnt[m] = 0;  e_ptr[m] = N - 1;
    end
    one    = 1;
    rr_set = (one << 2) | (one << 7) | (one << 23);

    // Reset with every enable asserted.
    rand_data();
    clear = 1'b1; src_out = '1;
    cycle(); cycle();
    chk("rst_bus",   b0, 0);
    chk("rst_vld",   v0, 0);
    chk("rst_gnt",   g0, 0);
    chk("rst_conf",  c0, 0);
    chk("rst_cnt",   n1, 0);

    // First post-reset sample.
    clear = 1'b0; src_out = one << 5; set_word(5, 32'hDEADBEEF);
    cycle();
    chk("first_bus", b0, 32'hDEADBEEF);
    chk("first_gnt", g0, one << 5);
    chk("first_vld", v0, 1);
    chk("first_conf", c0, 0);

    // Fixed priority with a two-source conflict.
    src_out = (one << 3) | (one << 20);
    set_word(3, 32'h11); set_word(20, 32'h22);
    cycle();
    chk("fp_bus",  b0, 32'h11);
    chk("fp_gnt",  g0, one << 3);
    chk("fp_conf", c0, 1);
    chk("fp_cnt",  n0, 1);
    repeat (4) cycle();
    chk("fp_bus_hold", b0, 32'h11);
    chk("fp_cnt5",     n0, 5);

    // Round-robin order and wrap-around from a fresh reset.
    clear = 1'b1; cycle(); clear = 1'b0;
    src_out = rr_set;
    exp_rr = '{2, 7, 23, 2};
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_order", g1, one << exp_rr[k]);
    end
    chk("rr_cnt4", n1, 4);

    // Hold freezes everything including the pointer.
    hold = 1'b1;
    repeat (3) begin
      src_out = N'($urandom);
      rand_data();
      cycle();
      chk("hold_gnt", g1, one << 2);
      chk("hold_cnt", n1, 4);
    end
    hold = 1'b0; src_out = rr_set;
    cycle();
    chk("hold_resume", g1, one << 7);

    // Counter saturation on the 4-bit instance.
    src_out = 24'h3;
    repeat (20) begin
      cycle();
      chk("sat_conf", c0, 1);
    end
    chk("sat_cnt", n0, 15);

    // Idle bus.
    src_out = '0;
    cycle();
    chk("idle_bus", b0, 0);
    chk("idle_vld", v0, 0);

`ifdef BUS_PARITY_EN
    src_out = one; set_word(0, 32'h7);
    cycle();
    chk("par_odd", p0, 1);
    set_word(0, 32'h3);
    cycle();
    chk("par_even", p0, 0);
`endif

    // Randomized traffic with occasional hold and clear.
    for (int c = 0; c < 400; c++) begin
      int nb;
      clear = ($urandom_range(0, 39) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      src_out = '0;
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) src_out[$urandom_range(0, N-1)] = 1'b1;
      rand_data();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
